// File: rtl/ikbd_serial_link.sv
// IKBD serial bridge: 8N1 LSB-first transmitter fed from the ACIA TX FIFO, receiver feeding the ACIA RX FIFO.
// Optional build macro IKBD_LINK_LOOPBACK_EN routes the internal ikbd_tx back into the receiver for self-test.
`timescale 1ns/1ps
module ikbd_serial_link #(
  parameter int CLKS_PER_BIT = 1024,
  parameter int STROBE_LEN   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ikbd_data_out_available,
  input  logic [7:0] ikbd_data_out,
  output logic       ikbd_strobe_out,
  output logic       ikbd_strobe_in,
  output logic [7:0] ikbd_data_in,
  output logic       ikbd_tx,
  input  logic       ikbd_rx,
  output logic       frame_err
);

  localparam int SW = $clog2(STROBE_LEN + 1);
  localparam logic [10:0]   BIT_RELOAD  = 11'(CLKS_PER_BIT - 1);
  localparam logic [10:0]   HALF_RELOAD = 11'(CLKS_PER_BIT / 2 - 1);
  localparam logic [SW-1:0] STB_LOAD    = SW'(STROBE_LEN);
  localparam logic [SW-1:0] STB_ONE     = SW'(1);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  tx_state_t     tx_state, tx_state_nxt;
  logic [9:0]    tx_shift;
  logic [3:0]    tx_bit;
  logic [10:0]   tx_sub;
  logic [SW-1:0] tx_stb;
  logic          tx_last;
  logic          tx_load;

  // A byte may load straight out of the stop bit so frames run back-to-back.
  assign tx_last = (tx_state == TX_SEND) && (tx_sub == 11'd0) && (tx_bit == 4'd9);
  assign tx_load = ikbd_data_out_available && ((tx_state == TX_IDLE) || tx_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_state <= TX_IDLE;
    else          tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE: if (ikbd_data_out_available) tx_state_nxt = TX_SEND;
      TX_SEND: if (tx_last) tx_state_nxt = ikbd_data_out_available ? TX_SEND : TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    ikbd_tx         = (tx_state == TX_SEND) ? tx_shift[0] : 1'b1;
    ikbd_strobe_out = (tx_stb != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift <= '1;
      tx_bit   <= '0;
      tx_sub   <= '0;
      tx_stb   <= '0;
    end else if (tx_load) begin
      tx_shift <= {1'b1, ikbd_data_out, 1'b0};
      tx_bit   <= '0;
      tx_sub   <= BIT_RELOAD;
      tx_stb   <= STB_LOAD;
    end else begin
      if (tx_stb != '0) tx_stb <= tx_stb - STB_ONE;
      if (tx_state == TX_SEND) begin
        if (tx_sub == 11'd0) begin
          tx_shift <= {1'b1, tx_shift[9:1]};
          tx_bit   <= tx_bit + 4'd1;
          tx_sub   <= BIT_RELOAD;
        end else begin
          tx_sub <= tx_sub - 11'd1;
        end
      end
    end
  end

  logic          rx_src;
  logic [1:0]    rx_sync;
  logic [1:0]    rx_hist;
  logic          rx_filt;
  rx_state_t     rx_state, rx_state_nxt;
  logic [7:0]    rx_shift;
  logic [3:0]    rx_bit;
  logic [10:0]   rx_sub;
  logic [SW-1:0] rx_stb;
  logic          rx_tick;

`ifdef IKBD_LINK_LOOPBACK_EN
  assign rx_src = ikbd_tx;
`else
  assign rx_src = ikbd_rx;
`endif

  // Majority of the synchronised sample and its two predecessors rejects single-clock spikes.
  assign rx_filt = (rx_sync[1] & rx_hist[0]) | (rx_sync[1] & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
  assign rx_tick = (rx_sub == 11'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync  <= 2'b11;
      rx_hist  <= 2'b11;
      rx_state <= RX_IDLE;
    end else begin
      rx_sync  <= {rx_sync[0], rx_src};
      rx_hist  <= {rx_hist[0], rx_sync[1]};
      rx_state <= rx_state_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_filt) rx_state_nxt = RX_START;
      RX_START: if (rx_tick) rx_state_nxt = rx_filt ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit == 4'd7)) rx_state_nxt = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_nxt = RX_WAIT;
      RX_WAIT:  if (rx_filt) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    ikbd_strobe_in = (rx_stb != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_shift     <= '0;
      rx_bit       <= '0;
      rx_sub       <= '0;
      rx_stb       <= '0;
      ikbd_data_in <= 8'h00;
      frame_err    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_stb != '0) rx_stb <= rx_stb - STB_ONE;
      case (rx_state)
        RX_IDLE: begin
          rx_sub <= HALF_RELOAD;
          rx_bit <= '0;
        end
        RX_START, RX_DATA, RX_STOP: begin
          rx_sub <= rx_tick ? BIT_RELOAD : rx_sub - 11'd1;
          if (rx_tick && rx_state == RX_DATA) begin
            rx_shift <= {rx_filt, rx_shift[7:1]};
            rx_bit   <= rx_bit + 4'd1;
          end
          if (rx_tick && rx_state == RX_STOP) begin
            if (rx_filt) begin
              ikbd_data_in <= rx_shift;
              rx_stb       <= STB_LOAD;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ikbd_serial_link.sv
// Bench for ikbd_serial_link: ACIA-side model on the TX FIFO, serial driver on ikbd_rx, and a
// frame-level reference (bit periods, expected bytes, strobe latencies) checked once per clock.
`timescale 1ns/1ps
module tb_ikbd_serial_link;

  localparam int CPB        = 64;
  localparam int STROBE_LEN = 2;
  // pin edge -> filtered edge (3) + one clock into START + 9.5 bit times to the stop centre
  localparam int RX_LAT     = 3 + 1 + (19 * CPB) / 2;

  logic       clk;
  logic       reset_n;
  logic       ikbd_data_out_available;
  logic [7:0] ikbd_data_out;
  logic       ikbd_strobe_out;
  logic       ikbd_strobe_in;
  logic [7:0] ikbd_data_in;
  logic       ikbd_tx;
  logic       ikbd_rx;
  logic       frame_err;

  ikbd_serial_link #(.CLKS_PER_BIT(CPB), .STROBE_LEN(STROBE_LEN)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .ikbd_data_out_available (ikbd_data_out_available),
    .ikbd_data_out           (ikbd_data_out),
    .ikbd_strobe_out         (ikbd_strobe_out),
    .ikbd_strobe_in          (ikbd_strobe_in),
    .ikbd_data_in            (ikbd_data_in),
    .ikbd_tx                 (ikbd_tx),
    .ikbd_rx                 (ikbd_rx),
    .frame_err               (frame_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] acia_q[$];
  logic [7:0] tx_plan[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
  int so_pulses = 0, so_len = 0;
  int si_pulses = 0, si_len = 0;
  int fe_pulses = 0, fe_len = 0;
  logic so_prev = 1'b0, si_prev = 1'b0, fe_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: ACIA TX FIFO model pops on strobe_out, RX strobes are scored against exp_q.
  task automatic tick();
    @(negedge clk);
    if (ikbd_strobe_out && !so_prev) begin
      so_pulses++;
      so_len = 1;
      if (acia_q.size() != 0) acia_q.delete(0);
    end else if (ikbd_strobe_out) so_len++;
    else if (so_prev) check("strobe_out_len", so_len, STROBE_LEN);
    so_prev = ikbd_strobe_out;
    ikbd_data_out_available = (acia_q.size() != 0);
    ikbd_data_out = (acia_q.size() != 0) ? acia_q[0] : 8'h00;

    if (ikbd_strobe_in && !si_prev) begin
      si_pulses++;
      si_len = 1;
      check("rx_strobe_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("rx_data", ikbd_data_in, exp_q.pop_front());
        check("rx_latency", cyc - start_q.pop_front(), RX_LAT);
      end
    end else if (ikbd_strobe_in) si_len++;
    else if (si_prev) check("strobe_in_len", si_len, STROBE_LEN);
    si_prev = ikbd_strobe_in;

    if (frame_err && !fe_prev) begin
      fe_pulses++;
      fe_len = 1;
    end else if (frame_err) fe_len++;
    else if (fe_prev) check("frame_err_len", fe_len, 1);
    fe_prev = frame_err;
  endtask

  // Queue tx_plan into the ACIA and check the line: each frame bit held exactly CPB clocks, no gaps.
  task automatic tx_frames();
    int p0, n, bad;
    logic [9:0] fr;
    p0 = so_pulses;
    n  = tx_plan.size();
    for (int f = 0; f < n; f++) begin
      acia_q.push_back(tx_plan[f]);
`ifdef IKBD_LINK_LOOPBACK_EN
      exp_q.push_back(tx_plan[f]);
      start_q.push_back(cyc + 1 + f * 10 * CPB);
`endif
    end
    ikbd_data_out_available = 1'b1;
    ikbd_data_out = acia_q[0];
    for (int f = 0; f < n; f++) begin
      fr = {1'b1, tx_plan[f], 1'b0};
      for (int i = 0; i < 10; i++) begin
        bad = 0;
        for (int c = 0; c < CPB; c++) begin
          tick();
          if (ikbd_tx !== fr[i]) bad++;
        end
        check("tx_bit_level", bad, 0);
      end
    end
    tick();
    check("tx_idle_after", ikbd_tx, 1);
    check("strobe_out_count", so_pulses - p0, n);
    tx_plan.delete();
  endtask

  // Drive one 8N1 frame on ikbd_rx; a good stop bit registers the byte with the scoreboard.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (stop) begin
      exp_q.push_back(b);
      start_q.push_back(cyc);
    end
    for (int i = 0; i < 10; i++) begin
      ikbd_rx = fr[i];
      repeat (CPB) tick();
    end
    ikbd_rx = stop;
  endtask

  initial begin
    int si0, fe0, so0, bad;
    logic [7:0] rb;
    logic [9:0] rxf;

    reset_n = 1'b0;
    ikbd_rx = 1'b1;
    ikbd_data_out_available = 1'b0;
    ikbd_data_out = 8'h00;
    repeat (4) tick();
    check("rst_tx", ikbd_tx, 1);
    check("rst_strobe_out", ikbd_strobe_out, 0);
    check("rst_strobe_in", ikbd_strobe_in, 0);
    check("rst_data_in", ikbd_data_in, 8'h00);
    check("rst_frame_err", frame_err, 0);
    reset_n = 1'b1;
    repeat (4) tick();

    // transmit: fixed pattern, back-to-back pair, then random back-to-back run
    tx_plan.push_back(8'hA5);
    tx_frames();
    repeat (5) tick();
    tx_plan.push_back(8'h80);
    tx_plan.push_back(8'h01);
    tx_frames();
    repeat ($urandom_range(1, 20)) tick();
    for (int i = 0; i < 3; i++) tx_plan.push_back(8'($urandom_range(0, 255)));
    tx_frames();
    repeat (CPB) tick();

`ifndef IKBD_LINK_LOOPBACK_EN
    // receive: fixed byte and random bytes with random idle gaps
    fe0 = fe_pulses;
    send_rx(8'h3C, 1'b1);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, CPB)) tick();
      send_rx(8'($urandom_range(0, 255)), 1'b1);
    end
    repeat (CPB) tick();
    check("rx_no_frame_err", fe_pulses - fe0, 0);
    check("rx_all_received", exp_q.size(), 0);

    // stop bit low, line held low well past one frame: exactly one error, no retrigger
    si0 = si_pulses;
    fe0 = fe_pulses;
    send_rx(8'hFF, 1'b0);
    repeat (12 * CPB) tick();
    check("ferr_count", fe_pulses - fe0, 1);
    check("ferr_no_strobe", si_pulses - si0, 0);
    ikbd_rx = 1'b1;
    repeat (CPB) tick();
    send_rx(8'($urandom_range(0, 255)), 1'b1);
    repeat (CPB) tick();
    check("ferr_rearm_rx", si_pulses - si0, 1);

    // short low glitch is rejected
    si0 = si_pulses;
    fe0 = fe_pulses;
    ikbd_rx = 1'b0;
    repeat ($urandom_range(4, CPB / 4)) tick();
    ikbd_rx = 1'b1;
    repeat (2 * CPB) tick();
    check("glitch_no_strobe", si_pulses - si0, 0);
    check("glitch_no_ferr", fe_pulses - fe0, 0);
    send_rx(8'h55, 1'b1);
    repeat (CPB) tick();
    check("glitch_then_rx", si_pulses - si0, 1);
`endif

    // reset at bit 4 of simultaneous TX and RX frames
    si0 = si_pulses;
    so0 = so_pulses;
    rb  = 8'($urandom_range(0, 255));
    rxf = {1'b1, rb, 1'b0};
    acia_q.push_back(8'($urandom_range(0, 255)));
    ikbd_data_out_available = 1'b1;
    ikbd_data_out = acia_q[0];
    for (int i = 0; i < 4 * CPB + CPB / 2; i++) begin
      ikbd_rx = rxf[i / CPB];
      tick();
    end
    reset_n = 1'b0;
    #1;
    check("midrst_tx", ikbd_tx, 1);
    check("midrst_strobe_in", ikbd_strobe_in, 0);
    check("midrst_data_in", ikbd_data_in, 8'h00);
    bad = 0;
    for (int i = 4 * CPB + CPB / 2; i < 10 * CPB; i++) begin
      ikbd_rx = rxf[i / CPB];
      tick();
      if (ikbd_tx !== 1'b1) bad++;
    end
    check("midrst_tx_held", bad, 0);
    ikbd_rx = 1'b1;
    repeat (8) tick();
    reset_n = 1'b1;
    repeat (2 * CPB) tick();
    check("midrst_no_strobe_in", si_pulses - si0, 0);
    check("midrst_one_strobe_out", so_pulses - so0, 1);
    check("midrst_tx_idle", ikbd_tx, 1);

`ifdef IKBD_LINK_LOOPBACK_EN
    tx_plan.push_back(8'h12);
    tx_frames();
`else
    send_rx(8'h12, 1'b1);
`endif
    repeat (2 * CPB) tick();
    check("final_rx_drained", exp_q.size(), 0);
    check("final_acia_drained", acia_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ikbd_serial_link.md
# ikbd_serial_link

Physical-layer bridge between the keyboard ACIA byte interface and the external IKBD serial line (7812.5 bit/s, 8N1, LSB first). On the transmit side it drains bytes the ACIA has queued for the keyboard processor and shifts them out on `ikbd_tx`. On the receive side it deserialises `ikbd_rx` and strobes completed bytes into the ACIA receive FIFO. It sits directly between the ACIA and the keyboard connector, on the 8 MHz CPU clock domain.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1024: clocks per serial bit. 8 MHz / 1024 = 7812.5 bit/s. Legal range is 16..2047.
- `STROBE_LEN`, default 2: clocks each strobe is held high.

Ports:
- `clk`  in  1  system clock, 8 MHz; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ikbd_data_out_available`  in  1  ACIA has a byte for the keyboard.
- `ikbd_data_out`  in  8  head of the ACIA TX FIFO.
- `ikbd_strobe_out`  out  1  pop pulse to the ACIA TX FIFO.
- `ikbd_strobe_in`  out  1  push pulse to the ACIA RX FIFO.
- `ikbd_data_in`  out  8  received byte; stable while `ikbd_strobe_in` is high and until the next frame completes.
- `ikbd_tx`  out  1  serial line to the keyboard; idles high.
- `ikbd_rx`  in  1  serial line from the keyboard; asynchronous.
- `frame_err`  out  1  one-clock pulse when a received stop bit is sampled low.

## Operation
Reset values while `reset_n`=0:
- `ikbd_tx`=1; `ikbd_strobe_out`=0; `ikbd_strobe_in`=0; `ikbd_data_in`=8'h00; `frame_err`=0.
- Both state machines in IDLE.
- Synchroniser flops=1.

Transmit FSM:
- IDLE: when `ikbd_data_out_available`=1, latch `ikbd_data_out` into the shift register as {1 stop, data[7:0], 0 start}. Assert `ikbd_strobe_out` and go to SEND.
- SEND: shift one bit every `CLKS_PER_BIT` clocks, 10 bits total.
  - `ikbd_strobe_out` stays high for exactly `STROBE_LEN` clocks and then drops.
  - `ikbd_data_out_available` is ignored during SEND, because the ACIA pointer update lags the strobe.
- After the stop bit's full period, return to IDLE. A new byte may start on the next clock, giving back-to-back frames with no gap.

Receive path:
- `ikbd_rx` passes through a 2-flop synchroniser, then a 3-sample majority filter clocked every clock.
- IDLE: a filtered falling edge enters START.
- START: wait `CLKS_PER_BIT/2` clocks, then resample.
  - If the line is high, treat it as a glitch and return to IDLE.
  - If the line is low, enter DATA.
- DATA: sample 8 bits at bit centres, spaced `CLKS_PER_BIT` apart, LSB first.
- STOP: sample the stop bit at its centre.
  - If the stop bit is 1: load `ikbd_data_in` and pulse `ikbd_strobe_in` for `STROBE_LEN` clocks.
  - If the stop bit is 0: pulse `frame_err` for 1 clock, discard the byte, and do not strobe.
  - In both cases wait for the filtered line to be high, then return to IDLE (a break condition does not retrigger).

General:
- TX and RX are fully independent; simultaneous activity is permitted.
- Bit counter is 4 bits. Sub-bit counter is 11 bits, counting down from `CLKS_PER_BIT-1` to 0.

## Timing
- TX latency: `ikbd_data_out_available` seen high at clock N gives `ikbd_tx`=0 (start bit) and `ikbd_strobe_out`=1 from clock N+1.
- TX frame: exactly `10*CLKS_PER_BIT` clocks (10240 at default).
- RX latency: the filtered start edge is 3 clocks (sync plus filter) after the pin edge.
- RX strobe: `ikbd_strobe_in` rises 9.5 bit times plus 1 clock after the filtered start edge.
- Minimum strobe spacing is one frame, which is greater than `2*STROBE_LEN`. This guarantees the ACIA's two-flop edge detector sees each strobe once.
- Reset asserted mid-frame: `ikbd_tx` returns to 1 immediately. The partial RX byte is discarded and no strobe is issued. After reset release, the FSMs start from IDLE.
- RX edge during STOP-wait: ignored until the line is high.

## Configuration
- `IKBD_LINK_LOOPBACK_EN`:
  - Defined: the receiver input is muxed to the internal `ikbd_tx` instead of `ikbd_rx`, and `ikbd_tx` is still driven to the pin. Bytes written by the CPU return through the ACIA RX FIFO, for self-test.
  - Undefined: no mux; the receiver uses `ikbd_rx` only.

## Test plan
- Present 8'hA5 with available=1 for one frame time -> strobe_out high 2 clocks; `ikbd_tx` = 0,1,0,1,0,0,1,0,1,1, each level held 1024 clocks.
- Keep available=1 with bytes 8'h80 then 8'h01 -> two frames back-to-back, exactly 20480 clocks from first start bit to end of second stop bit; two strobe_out pulses.
- Drive `ikbd_rx` with 8'h3C at 1024 clocks/bit -> one strobe_in pulse of 2 clocks with `ikbd_data_in`=8'h3C; `frame_err`=0.
- Drive an 8'hFF frame with the stop bit low -> `frame_err` pulses once; no strobe_in; the receiver rearms only after the line returns high.
- Apply a 200-clock low glitch on `ikbd_rx` -> no strobe, no `frame_err`; then send 8'h55 -> received correctly.
- Assert reset_n=0 at bit 4 of a TX and an RX frame -> `ikbd_tx`=1 immediately and no strobes; after release, an 8'h12 round-trip with `IKBD_LINK_LOOPBACK_EN` defined yields strobe_in with 8'h12.
